dma_read_engine: RTL and testbench

- Sits directly downstream of the memory request arbiter, on its DMA port.
- Receives register writes decoded from the MIPS/AXI-Lite write path and raises mem_requst_ack to ask for the shared read port.
- While granted (mem_enable_ack), reads a contiguous block of words from ideal_mem, buffers them in a small FIFO and streams them out with their destination word addresses.
- Signals completion with a one-cycle done pulse to the interrupt controller.

---
 rtl/dma_pkg.sv | 19 +
 rtl/dma_sync_fifo.sv | 59 +++++
 rtl/dma_read_engine.sv | 157 +++++++++++++++
 tb/tb_dma_read_engine.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared encodings for the DMA read engine: FSM states and register map.
package dma_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } dma_state_e;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned LEN_WIDTH      = 16;

endpackage

// File: rtl/dma_sync_fifo.sv
// First-word-fall-through synchronous FIFO used as the DMA read buffer.
module dma_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           din,
  output logic [Width-1:0]           dout,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_idx;
  logic [PtrW-1:0]  rd_idx;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CntW'(Depth));
  // Forced to zero when empty so the stream data reads 0 out of reset.
  assign dout    = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_idx <= wr_idx + PtrW'(1);
      end
      if (do_pop) begin
        rd_idx <= rd_idx + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_read_engine.sv
// DMA read engine: reads a block from ideal_mem through the arbiter's DMA port
// and streams the words out with their destination word addresses.
module dma_read_engine
  import dma_pkg::*;
#(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH         = 16,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic [ADDR_WIDTH-3:0]         reg_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] reg_data,
  input  logic                          reg_write,
  output logic                          mem_requst_ack,
  input  logic                          mem_enable_ack,
  output logic [ADDR_WIDTH-3:0]         dma_raddr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] dma_rdata,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-3:0]         m_addr,
  output logic                          busy,
  output logic                          done_irq
);

  localparam int unsigned AW = ADDR_WIDTH - 2;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  dma_state_e           state;
  logic [AW-1:0]        src_reg;
  logic [AW-1:0]        dst_reg;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [LEN_WIDTH-1:0] rd_left;
  logic [LEN_WIDTH-1:0] wr_left;
  logic                 inflight;
  logic                 start_pend;
  logic                 start_write;
  logic                 grant;
  logic                 pop;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 unused_bits;

  assign start_write = reg_write && (reg_addr[1:0] == REG_CTRL) && reg_data[CTRL_START_BIT];

  // Count the in-flight read so the FIFO has room for every issued grant.
  assign mem_requst_ack = (state == StRun) && (rd_left != '0) &&
                          ((32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH);
  assign grant     = mem_requst_ack && mem_enable_ack;
  assign dma_raddr = rd_ptr;
  assign m_valid   = !fifo_empty;
  assign m_addr    = wr_ptr;
  assign pop       = m_valid && m_ready;

  assign unused_bits = ^{reg_addr, reg_data, fifo_full};

  dma_sync_fifo #(
    .Width (C_M_AXI_DATA_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXI_ACLK),
    .rst_n (M_AXI_ARESETN),
    .push  (inflight),
    .pop   (pop),
    .din   (dma_rdata),
    .dout  (m_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      src_reg <= '0;
      dst_reg <= '0;
      len_reg <= '0;
    end else if (reg_write && !busy) begin
      unique case (reg_addr[1:0])
        REG_SRC: src_reg <= reg_data[AW-1:0];
        REG_DST: dst_reg <= reg_data[AW-1:0];
        REG_LEN: len_reg <= reg_data[LEN_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // START is latched for one cycle before the FSM acts on it.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state      <= StIdle;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rd_left    <= '0;
      wr_left    <= '0;
      inflight   <= 1'b0;
      start_pend <= 1'b0;
      busy       <= 1'b0;
      done_irq   <= 1'b0;
    end else begin
      inflight <= grant;
      done_irq <= 1'b0;
      if (grant) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_left <= rd_left - LEN_WIDTH'(1);
      end
      if (pop) begin
        wr_ptr  <= wr_ptr + AW'(1);
        wr_left <= wr_left - LEN_WIDTH'(1);
      end
      unique case (state)
        StIdle: begin
          if (start_pend) begin
            start_pend <= 1'b0;
            if (len_reg != '0) begin
              state   <= StRun;
              busy    <= 1'b1;
              rd_ptr  <= src_reg;
              wr_ptr  <= dst_reg;
              rd_left <= len_reg;
              wr_left <= len_reg;
            end else begin
              state    <= StDone;
              done_irq <= 1'b1;
            end
          end else if (start_write) begin
            start_pend <= 1'b1;
          end
        end
        StRun: begin
          if (rd_left == '0) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          // Enter DONE as the last word leaves so the pulse follows that pop.
          if ((wr_left == '0) || (pop && (wr_left == LEN_WIDTH'(1)))) begin
            state    <= StDone;
            busy     <= 1'b0;
            done_irq <= 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
          if (start_write) begin
            start_pend <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_read_engine.sv
// Directed bench for dma_read_engine with a read-address/stream scoreboard.
module tb_dma_read_engine;
  import dma_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 14;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_data;
  logic          reg_write;
  logic          mem_requst_ack;
  logic          mem_enable_ack;
  logic [AW-1:0] dma_raddr;
  logic [DW-1:0] dma_rdata = 32'h0BAD_F00D;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic          busy;
  logic          done_irq;

  always #5 clk = ~clk;

  dma_read_engine #(
    .C_M_AXI_DATA_WIDTH (DW),
    .ADDR_WIDTH         (16),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .M_AXI_ACLK     (clk),
    .M_AXI_ARESETN  (rst_n),
    .reg_addr       (reg_addr),
    .reg_data       (reg_data),
    .reg_write      (reg_write),
    .mem_requst_ack (mem_requst_ack),
    .mem_enable_ack (mem_enable_ack),
    .dma_raddr      (dma_raddr),
    .dma_rdata      (dma_rdata),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_addr         (m_addr),
    .busy           (busy),
    .done_irq       (done_irq)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int grant_cnt = 0;
  int stream_cnt = 0;
  int done_cnt = 0;
  int occ = 0;
  int last_pop_cyc = 0;
  int done_cyc = 0;
  logic grant_prev = 1'b0;
  logic pend_v = 1'b0;
  logic [DW-1:0] pend_d = '0;
  logic stall_prev = 1'b0;
  logic [AW+DW-1:0] held = '0;
  logic mon_g, mon_p;

  logic [AW-1:0]    exp_raddr[$];
  logic [AW+DW-1:0] exp_stream[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {4'hD, a, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model, scoreboard and FIFO occupancy model, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      occ        = 0;
      grant_prev = 1'b0;
      pend_v     = 1'b0;
      stall_prev = 1'b0;
      dma_rdata  = 32'h0BAD_F00D;
    end else begin
      dma_rdata = pend_v ? pend_d : 32'h0BAD_F00D;
      mon_g = mem_requst_ack && mem_enable_ack;
      mon_p = m_valid && m_ready;
      check("m_valid_vs_model", m_valid, occ != 0);
      if (stall_prev && m_valid) check("stall_stable", {m_addr, m_data}, held);
      if (mon_g) begin
        grant_cnt++;
        check("grant_expected", exp_raddr.size() != 0, 1);
        if (exp_raddr.size() != 0) check("read_addr", dma_raddr, exp_raddr.pop_front());
      end
      if (mon_p) begin
        stream_cnt++;
        last_pop_cyc = cyc;
        check("stream_expected", exp_stream.size() != 0, 1);
        if (exp_stream.size() != 0) check("stream_word", {m_addr, m_data}, exp_stream.pop_front());
      end
      if (done_irq) begin
        done_cnt++;
        done_cyc = cyc;
      end
      occ = occ + (grant_prev ? 1 : 0) - (mon_p ? 1 : 0);
      check("fifo_no_overflow", occ <= int'(DEPTH), 1);
      grant_prev = mon_g;
      pend_v     = mon_g;
      pend_d     = mem_word(dma_raddr);
      stall_prev = m_valid && !m_ready;
      held       = {m_addr, m_data};
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    reg_addr  = {12'h000, a};
    reg_data  = d;
    reg_write = 1'b1;
    step(1);
    reg_write = 1'b0;
  endtask

  task automatic expect_xfer(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len);
    for (int i = 0; i < len; i++) begin
      exp_raddr.push_back(src + AW'(i));
      exp_stream.push_back({dst + AW'(i), mem_word(src + AW'(i))});
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      step(1);
      i++;
    end
    check(tag, done_cnt - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, s0, d0, w;
    reg_addr = '0;
    reg_data = '0;
    reg_write = 1'b0;
    mem_enable_ack = 1'b0;
    m_ready = 1'b0;
    step(2);
    check("rst_req", mem_requst_ack, 0);
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_irq, 0);
    check("rst_raddr", dma_raddr, 0);
    check("rst_mdata", m_data, 0);
    check("rst_maddr", m_addr, 0);
    rst_n = 1'b1;
    step(1);

    // Basic 3-word transfer, always granted and accepted.
    mem_enable_ack = 1'b1;
    m_ready = 1'b1;
    reg_wr(REG_SRC, 32'h100);
    reg_wr(REG_DST, 32'h200);
    reg_wr(REG_LEN, 32'd3);
    g0 = grant_cnt; s0 = stream_cnt; d0 = done_cnt;
    expect_xfer(14'h100, 14'h200, 3);
    reg_wr(REG_CTRL, 32'h1);
    step(2);
    check("t1_busy", busy, 1);
    wait_done("t1_done", 40);
    check("t1_done_after_last_pop", done_cyc, last_pop_cyc + 1);
    check("t1_grants", grant_cnt - g0, 3);
    check("t1_stream", stream_cnt - s0, 3);
    step(3);
    check("t1_busy_cleared", busy, 0);
    check("t1_single_done", done_cnt - d0, 1);
    check("t1_queue_empty", exp_stream.size(), 0);

    // Consumer stalled: buffer fills, requests stop, then drains.
    m_ready = 1'b0;
    reg_wr(REG_LEN, 32'd6);
    g0 = grant_cnt; s0 = stream_cnt;
    expect_xfer(14'h100, 14'h200, 6);
    reg_wr(REG_CTRL, 32'h1);
    step(20);
    check("t2_grants_fill", grant_cnt - g0, DEPTH);
    check("t2_req_off", mem_requst_ack, 0);
    check("t2_no_stream", stream_cnt - s0, 0);
    check("t2_valid", m_valid, 1);
    check("t2_maddr_head", m_addr, 14'h200);
    check("t2_mdata_head", m_data, mem_word(14'h100));
    m_ready = 1'b1;
    wait_done("t2_done", 60);
    check("t2_grants", grant_cnt - g0, 6);
    check("t2_stream", stream_cnt - s0, 6);

    // Grant withheld: request stays up, nothing moves.
    mem_enable_ack = 1'b0;
    reg_wr(REG_LEN, 32'd3);
    g0 = grant_cnt; s0 = stream_cnt;
    expect_xfer(14'h100, 14'h200, 3);
    reg_wr(REG_CTRL, 32'h1);
    step(2);
    check("t3_req_on", mem_requst_ack, 1);
    step(10);
    check("t3_no_grant", grant_cnt - g0, 0);
    check("t3_no_stream", stream_cnt - s0, 0);
    check("t3_req_held", mem_requst_ack, 1);
    mem_enable_ack = 1'b1;
    wait_done("t3_done", 40);
    check("t3_stream", stream_cnt - s0, 3);

    // LEN=0: no-op, done two cycles after the START write.
    reg_wr(REG_LEN, 32'd0);
    g0 = grant_cnt; s0 = stream_cnt; d0 = done_cnt;
    w = cyc + 1;
    reg_wr(REG_CTRL, 32'h1);
    step(4);
    check("t4_done_once", done_cnt - d0, 1);
    check("t4_done_timing", done_cyc, w + 2);
    check("t4_no_grant", grant_cnt - g0, 0);
    check("t4_no_stream", stream_cnt - s0, 0);

    // SRC and START written while busy are ignored.
    reg_wr(REG_LEN, 32'd4);
    g0 = grant_cnt; s0 = stream_cnt; d0 = done_cnt;
    expect_xfer(14'h100, 14'h200, 4);
    reg_wr(REG_CTRL, 32'h1);
    step(2);
    reg_wr(REG_SRC, 32'h300);
    reg_wr(REG_CTRL, 32'h1);
    wait_done("t5_done", 40);
    step(4);
    check("t5_grants", grant_cnt - g0, 4);
    check("t5_stream", stream_cnt - s0, 4);
    check("t5_single_done", done_cnt - d0, 1);

    // Asynchronous reset mid-RUN with two words buffered.
    m_ready = 1'b0;
    reg_wr(REG_LEN, 32'd6);
    expect_xfer(14'h100, 14'h200, 6);
    reg_wr(REG_CTRL, 32'h1);
    for (int i = 0; i < 20 && occ != 2; i++) step(1);
    check("t6_two_buffered", occ, 2);
    check("t6_pre_busy", busy, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_req", mem_requst_ack, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_mdata", m_data, 0);
    exp_raddr.delete();
    exp_stream.delete();
    step(2);
    rst_n = 1'b1;
    step(3);
    check("t6_no_done", done_cnt - d0, 0);

    // Registers cleared: LEN=0 no-op, then SRC=DST=0 for a 1-word transfer.
    m_ready = 1'b1;
    g0 = grant_cnt; d0 = done_cnt;
    reg_wr(REG_CTRL, 32'h1);
    step(5);
    check("t6_len_zero_no_grant", grant_cnt - g0, 0);
    check("t6_len_zero_done", done_cnt - d0, 1);
    s0 = stream_cnt;
    reg_wr(REG_LEN, 32'd1);
    expect_xfer(14'h000, 14'h000, 1);
    reg_wr(REG_CTRL, 32'h1);
    wait_done("t6_post_done", 40);
    check("t6_post_stream", stream_cnt - s0, 1);
    check("t6_post_queue_empty", exp_stream.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
